ysyx_rsv: RTL and testbench
===========================

YSYX_RSV -- requirements
Module: ysyx_rsv

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter RS_SIZE, default 4, number of reservation entries (power of two, >=2).
REQ-003 SHALL have parameter TAG_W, default 4, ROB tag width; tag value 0 means "operand ready"; tag t>0 names ROB slot t-1.
REQ-004 SHALL have ports: clock  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have ports: reset  in  1  synchronous, active-low (0 = reset).
REQ-006 SHALL have ports: flush  in  1  pipeline flush from commit stage.
REQ-007 SHALL have ports: in_valid in 1, in_ready out 1: dispatch handshake from issue queue.
REQ-008 SHALL have ports: in_alu_op in 5, in_op1 in XLEN, in_op2 in XLEN, in_imm in 32, in_pc in XLEN: dispatched micro-op fields.
REQ-009 SHALL have ports: in_qj in TAG_W, in_qk in TAG_W: producer tags of op1/op2 (0 = value valid).
REQ-010 SHALL have ports: in_dest in TAG_W: ROB tag of this micro-op (never 0).
REQ-011 SHALL have ports: cdb_valid in 1, cdb_dest in TAG_W, cdb_result in XLEN: common data bus broadcast.
REQ-012 SHALL have ports: out_valid out 1, out_ready in 1: issue handshake to ALU.
REQ-013 SHALL have ports: out_alu_op out 5, out_op1 out XLEN, out_op2 out XLEN, out_imm out 32, out_pc out XLEN, out_dest out TAG_W: issued micro-op.
REQ-014 SHALL have ports: count out clog2(RS_SIZE)+1: number of busy entries.

Function
REQ-015 Each entry SHALL hold busy, age, alu_op, op1, op2, qj, qk, imm, pc, dest.
REQ-016 in_ready SHALL be 1 iff at least one entry is non-busy at cycle start; an issue in the same cycle does not raise in_ready.
REQ-017 On in_valid && in_ready && !flush, the lowest-index free entry SHALL be written and marked busy with age 0.
REQ-018 On accept, all other busy entries not issuing this cycle SHALL increment age (saturating at RS_SIZE-1).
REQ-019 Wakeup: when cdb_valid && cdb_dest!=0, every busy entry with qj==cdb_dest SHALL set op1=cdb_result, qj=0 at the edge; likewise qk/op2.
REQ-020 Capture bypass: an entry accepted in the same cycle with in_qj (in_qk)==cdb_dest, cdb_valid, cdb_dest!=0 SHALL store cdb_result and tag 0.
REQ-021 cdb_valid with cdb_dest==0 SHALL be ignored.
REQ-022 An entry is ready iff busy && qj==0 && qk==0, evaluated on registered state; an entry woken at edge N is eligible from cycle N+1.
REQ-023 out_valid SHALL be 1 iff any entry is ready; out_* SHALL be combinational from the selected entry.
REQ-024 Selection SHALL be the ready entry with greatest age; ties broken by lowest index.
REQ-025 out_* SHALL be stable while out_valid && !out_ready, unless flush or an older entry becomes ready.
REQ-026 On out_valid && out_ready, the selected entry SHALL be cleared (busy=0) at the edge.
REQ-027 Accept and issue in the same cycle SHALL both take effect; count SHALL change by +1, -1 or 0 accordingly.
REQ-028 When full (count==RS_SIZE), in_ready=0 and in_valid SHALL be ignored with no state change.
REQ-029 When empty, out_valid=0 and out_ready SHALL be ignored.
REQ-030 flush SHALL clear all busy bits at the edge; input accepted that cycle is discarded; issue handshake that cycle has no effect on state.
REQ-031 count SHALL equal the popcount of busy bits; width arithmetic unsigned, no overflow.

Reset
REQ-032 While reset==0 at an edge, all busy bits SHALL clear and ages zero; in_valid, cdb_valid, out_ready ignored.
REQ-033 After reset: in_ready=1, out_valid=0, count=0, out_* fields =0 (selected entry 0 contents cleared).
REQ-034 Reset asserted mid-operation SHALL discard all entries in one cycle identically to REQ-032.

Verification
REQ-035 Ready-in bypass: dispatch op (qj=0,qk=0,op1=5,op2=7,dest=3) with out_ready=1 -> out_valid=1 next cycle, out_op1=5, out_op2=7, out_dest=3; count returns 0 after handshake.
REQ-036 Wakeup: dispatch qj=2; cycle later cdb_valid, cdb_dest=2, cdb_result=0xDEAD -> out_valid=0 during broadcast cycle, out_valid=1 and out_op1=0xDEAD following cycle.
REQ-037 Same-cycle capture: dispatch qk=4 while cdb_dest=4, cdb_result=9 -> entry ready next cycle with out_op2=9.
REQ-038 Full/oldest-first: fill RS_SIZE=4 entries all waiting on tag 1, out_ready=1 -> in_ready=0, count=4; broadcast tag 1 -> issue order equals dispatch order over 4 cycles, in_ready=1 after first issue.
REQ-039 Flush: 3 busy entries, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1.
REQ-040 Reset mid-operation: 2 busy entries, reset=0 one cycle -> count=0, out_valid=0; cdb broadcast during reset causes no wakeup.

Source files
------------

// File: rtl/ysyx_rsv.sv
// Reservation station: holds dispatched micro-ops until both operands are
// available, captures results from the common data bus, and issues the
// oldest ready entry to the ALU.
module ysyx_rsv #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RS_SIZE = 4,
    parameter int unsigned TAG_W   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4:0]                in_alu_op,
    input  logic [XLEN-1:0]           in_op1,
    input  logic [XLEN-1:0]           in_op2,
    input  logic [31:0]               in_imm,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [TAG_W-1:0]          in_qj,
    input  logic [TAG_W-1:0]          in_qk,
    input  logic [TAG_W-1:0]          in_dest,
    input  logic                      cdb_valid,
    input  logic [TAG_W-1:0]          cdb_dest,
    input  logic [XLEN-1:0]           cdb_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4:0]                out_alu_op,
    output logic [XLEN-1:0]           out_op1,
    output logic [XLEN-1:0]           out_op2,
    output logic [31:0]               out_imm,
    output logic [XLEN-1:0]           out_pc,
    output logic [TAG_W-1:0]          out_dest,
    output logic [$clog2(RS_SIZE):0]  count
);

    localparam int unsigned IdxW = $clog2(RS_SIZE);
    localparam int unsigned CntW = IdxW + 1;
    localparam logic [IdxW-1:0] AgeMax = IdxW'(RS_SIZE - 1);

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [IdxW-1:0]    age_q    [RS_SIZE];
    logic [IdxW-1:0]    age_d    [RS_SIZE];
    logic [4:0]         alu_op_q [RS_SIZE];
    logic [4:0]         alu_op_d [RS_SIZE];
    logic [XLEN-1:0]    op1_q    [RS_SIZE];
    logic [XLEN-1:0]    op1_d    [RS_SIZE];
    logic [XLEN-1:0]    op2_q    [RS_SIZE];
    logic [XLEN-1:0]    op2_d    [RS_SIZE];
    logic [TAG_W-1:0]   qj_q     [RS_SIZE];
    logic [TAG_W-1:0]   qj_d     [RS_SIZE];
    logic [TAG_W-1:0]   qk_q     [RS_SIZE];
    logic [TAG_W-1:0]   qk_d     [RS_SIZE];
    logic [31:0]        imm_q    [RS_SIZE];
    logic [31:0]        imm_d    [RS_SIZE];
    logic [XLEN-1:0]    pc_q     [RS_SIZE];
    logic [XLEN-1:0]    pc_d     [RS_SIZE];
    logic [TAG_W-1:0]   dest_q   [RS_SIZE];
    logic [TAG_W-1:0]   dest_d   [RS_SIZE];

    logic            sel_found;
    logic [IdxW-1:0] sel_idx;
    logic [IdxW-1:0] sel_age;
    logic            free_found;
    logic [IdxW-1:0] free_idx;
    logic [CntW-1:0] busy_cnt;
    logic            accept;
    logic            issue;
    logic            cdb_hit;

    // Pick the oldest ready entry; strict '>' keeps the lowest index on ties.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            if (busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0) &&
                (!sel_found || (age_q[i] > sel_age))) begin
                sel_found = 1'b1;
                sel_idx   = IdxW'(i);
                sel_age   = age_q[i];
            end
        end
    end

    // Lowest-index free slot and occupancy count, both from registered state.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        busy_cnt   = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            busy_cnt = busy_cnt + CntW'(busy_q[i]);
            if (!busy_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
        end
    end

    // Outputs are driven straight from the selected entry.
    always_comb begin
        in_ready   = free_found;
        out_valid  = sel_found;
        out_alu_op = alu_op_q[sel_idx];
        out_op1    = op1_q[sel_idx];
        out_op2    = op2_q[sel_idx];
        out_imm    = imm_q[sel_idx];
        out_pc     = pc_q[sel_idx];
        out_dest   = dest_q[sel_idx];
        count      = busy_cnt;
    end

    // Next state: wakeup, ageing, issue clear, accept with bypass, then flush.
    always_comb begin
        accept  = in_valid && free_found;
        issue   = sel_found && out_ready;
        cdb_hit = cdb_valid && (cdb_dest != '0);

        busy_d   = busy_q;
        age_d    = age_q;
        alu_op_d = alu_op_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        qj_d     = qj_q;
        qk_d     = qk_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        dest_d   = dest_q;

        for (int i = 0; i < int'(RS_SIZE); i++) begin
            if (busy_q[i] && !(issue && (sel_idx == IdxW'(i)))) begin
                if (cdb_hit && (qj_q[i] == cdb_dest)) begin
                    op1_d[i] = cdb_result;
                    qj_d[i]  = '0;
                end
                if (cdb_hit && (qk_q[i] == cdb_dest)) begin
                    op2_d[i] = cdb_result;
                    qk_d[i]  = '0;
                end
                if (accept && (age_q[i] != AgeMax)) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end

        if (issue) begin
            busy_d[sel_idx] = 1'b0;
        end

        if (accept) begin
            busy_d[free_idx]   = 1'b1;
            age_d[free_idx]    = '0;
            alu_op_d[free_idx] = in_alu_op;
            imm_d[free_idx]    = in_imm;
            pc_d[free_idx]     = in_pc;
            dest_d[free_idx]   = in_dest;
            // A result broadcast in the dispatch cycle would otherwise be missed.
            if (cdb_hit && (in_qj == cdb_dest)) begin
                op1_d[free_idx] = cdb_result;
                qj_d[free_idx]  = '0;
            end else begin
                op1_d[free_idx] = in_op1;
                qj_d[free_idx]  = in_qj;
            end
            if (cdb_hit && (in_qk == cdb_dest)) begin
                op2_d[free_idx] = cdb_result;
                qk_d[free_idx]  = '0;
            end else begin
                op2_d[free_idx] = in_op2;
                qk_d[free_idx]  = in_qk;
            end
        end

        if (flush) begin
            busy_d = '0;
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                age_d[i] = '0;
            end
        end
    end

    // State registers; reset also clears contents so out_* read zero afterwards.
    always_ff @(posedge clock) begin
        if (!reset) begin
            busy_q <= '0;
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                age_q[i]    <= '0;
                alu_op_q[i] <= '0;
                op1_q[i]    <= '0;
                op2_q[i]    <= '0;
                qj_q[i]     <= '0;
                qk_q[i]     <= '0;
                imm_q[i]    <= '0;
                pc_q[i]     <= '0;
                dest_q[i]   <= '0;
            end
        end else begin
            busy_q   <= busy_d;
            age_q    <= age_d;
            alu_op_q <= alu_op_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            qj_q     <= qj_d;
            qk_q     <= qk_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            dest_q   <= dest_d;
        end
    end

endmodule

// File: tb/tb_ysyx_rsv.sv
// Randomised plus directed bench for ysyx_rsv with a scoreboard of issued ops.
module tb_ysyx_rsv;

    localparam int N = 4;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [4:0]  in_alu_op;
    logic [31:0] in_op1, in_op2, in_imm, in_pc;
    logic [3:0]  in_qj, in_qk, in_dest;
    logic        cdb_valid;
    logic [3:0]  cdb_dest;
    logic [31:0] cdb_result;
    logic        out_valid, out_ready;
    logic [4:0]  out_alu_op;
    logic [31:0] out_op1, out_op2, out_imm, out_pc;
    logic [3:0]  out_dest;
    logic [2:0]  count;

    ysyx_rsv #(.XLEN(32), .RS_SIZE(N), .TAG_W(4)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
        .in_op1(in_op1), .in_op2(in_op2), .in_imm(in_imm), .in_pc(in_pc),
        .in_qj(in_qj), .in_qk(in_qk), .in_dest(in_dest),
        .cdb_valid(cdb_valid), .cdb_dest(cdb_dest), .cdb_result(cdb_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
        .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm), .out_pc(out_pc),
        .out_dest(out_dest), .count(count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  dest;
    } iss_t;

    iss_t sb[$];
    int checks = 0;
    int failures = 0;

    // Reference model: one record per slot, updated from the stated rules.
    logic        m_busy [N];
    int          m_age  [N];
    iss_t        m_ent  [N];
    logic [3:0]  m_qj   [N];
    logic [3:0]  m_qk   [N];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_age[i]  = 0;
            m_ent[i]  = '0;
            m_qj[i]   = '0;
            m_qk[i]   = '0;
        end
    endtask

    // Monitor: every DUT issue handshake must match the next predicted op.
    initial begin
        iss_t e;
        forever begin
            @(negedge clock);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("issue_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("issue", {out_alu_op, out_op1, out_op2, out_imm, out_pc, out_dest}, e);
                end
            end
        end
    end

    // One clock: predict, push expected issue, check at negedge, advance model.
    task automatic step();
        int cnt, sel, fr;
        logic iss, acc, hit;
        cnt = 0; sel = -1; fr = -1;
        for (int i = 0; i < N; i++) begin
            if (m_busy[i]) cnt++;
            else if (fr < 0) fr = i;
        end
        for (int i = 0; i < N; i++) begin
            if (m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0 && (sel < 0 || m_age[i] > m_age[sel]))
                sel = i;
        end
        if (sel >= 0 && out_ready) sb.push_back(m_ent[sel]);

        @(negedge clock);
        #1;
        chk("in_ready", in_ready, cnt < N);
        chk("count", count, cnt);
        chk("out_valid", out_valid, sel >= 0);
        if (sel >= 0 && out_ready && !out_valid) sb.delete();

        if (!reset) begin
            model_clear();
        end else if (flush) begin
            for (int i = 0; i < N; i++) begin
                m_busy[i] = 1'b0;
                m_age[i]  = 0;
            end
        end else begin
            iss = (sel >= 0) && out_ready;
            acc = in_valid && (fr >= 0);
            hit = cdb_valid && (cdb_dest != 0);
            for (int i = 0; i < N; i++) begin
                if (m_busy[i] && !(iss && i == sel)) begin
                    if (hit && m_qj[i] == cdb_dest) begin m_ent[i].op1 = cdb_result; m_qj[i] = 0; end
                    if (hit && m_qk[i] == cdb_dest) begin m_ent[i].op2 = cdb_result; m_qk[i] = 0; end
                    if (acc && m_age[i] < N - 1) m_age[i]++;
                end
            end
            if (iss) m_busy[sel] = 1'b0;
            if (acc) begin
                m_busy[fr] = 1'b1;
                m_age[fr]  = 0;
                m_ent[fr]  = '{op: in_alu_op, op1: in_op1, op2: in_op2, imm: in_imm,
                               pc: in_pc, dest: in_dest};
                m_qj[fr] = in_qj;
                m_qk[fr] = in_qk;
                if (hit && in_qj == cdb_dest) begin m_ent[fr].op1 = cdb_result; m_qj[fr] = 0; end
                if (hit && in_qk == cdb_dest) begin m_ent[fr].op2 = cdb_result; m_qk[fr] = 0; end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle(input logic rdy);
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_alu_op = '0;
        in_op1 = '0; in_op2 = '0; in_imm = '0; in_pc = '0;
        in_qj = '0; in_qk = '0; in_dest = 4'd1;
        cdb_valid = 1'b0; cdb_dest = '0; cdb_result = '0; out_ready = rdy;
    endtask

    task automatic dispatch(input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] qj, input logic [3:0] qk, input logic [3:0] dst);
        in_valid  = 1'b1;
        in_alu_op = 5'($urandom);
        in_op1 = a; in_op2 = b; in_qj = qj; in_qk = qk; in_dest = dst;
        in_imm = $urandom; in_pc = $urandom;
    endtask

    initial begin
        model_clear();
        set_idle(1'b1);
        reset = 1'b0;
        cdb_valid = 1'b1; cdb_dest = 4'd1; in_valid = 1'b1;
        @(posedge clock);
        #1;
        step();
        set_idle(1'b1);
        chk("reset_fields", {out_alu_op, out_op1, out_op2, out_imm, out_pc, out_dest}, 0);

        // Ready operands issue the cycle after dispatch.
        dispatch(32'd5, 32'd7, 4'd0, 4'd0, 4'd3); step();
        set_idle(1'b1); step(); step();

        // Wakeup from the CDB; eligible one cycle after the broadcast.
        dispatch(32'd1, 32'd2, 4'd2, 4'd0, 4'd5); step();
        set_idle(1'b1); cdb_valid = 1'b1; cdb_dest = 4'd2; cdb_result = 32'hDEAD; step();
        set_idle(1'b1); step(); step();

        // Capture bypass on the dispatch cycle; a zero-tag broadcast does nothing.
        dispatch(32'd1, 32'd2, 4'd0, 4'd4, 4'd6);
        cdb_valid = 1'b1; cdb_dest = 4'd4; cdb_result = 32'd9; step();
        set_idle(1'b1); cdb_valid = 1'b1; cdb_dest = 4'd0; step();
        step();

        // Fill, overflow attempt, then release in dispatch order.
        for (int i = 0; i < N + 1; i++) begin
            set_idle(1'b1); dispatch($urandom, $urandom, 4'd1, 4'd0, 4'(7 + i)); step();
        end
        set_idle(1'b1); cdb_valid = 1'b1; cdb_dest = 4'd1; cdb_result = 32'h1234; step();
        set_idle(1'b1);
        for (int i = 0; i < N + 1; i++) step();

        // Flush with a concurrent dispatch and issue attempt.
        for (int i = 0; i < 3; i++) begin
            set_idle(1'b0); dispatch($urandom, $urandom, 4'd3, 4'd0, 4'(2 + i)); step();
        end
        set_idle(1'b1); flush = 1'b1; dispatch(32'd1, 32'd1, 4'd0, 4'd0, 4'd9); step();
        set_idle(1'b1); step();

        // Reset mid-operation swallows a broadcast.
        for (int i = 0; i < 2; i++) begin
            set_idle(1'b0); dispatch($urandom, $urandom, 4'd2, 4'd0, 4'(3 + i)); step();
        end
        set_idle(1'b1); reset = 1'b0; cdb_valid = 1'b1; cdb_dest = 4'd2; step();
        set_idle(1'b1); step(); step();

        // Random traffic with a small tag space so wakeups and ties are frequent.
        for (int c = 0; c < 600; c++) begin
            set_idle($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 9) < 7)
                dispatch($urandom, $urandom,
                         ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 4)),
                         ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 4)),
                         4'($urandom_range(1, 15)));
            cdb_valid  = $urandom_range(0, 1);
            cdb_dest   = 4'($urandom_range(0, 4));
            cdb_result = $urandom;
            flush      = ($urandom_range(0, 39) == 0);
            reset      = !($urandom_range(0, 79) == 0);
            step();
        end

        set_idle(1'b1);
        step();
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
